msrv32_trap_controller: RTL and testbench
=========================================

// Module: msrv32_trap_controller
// PURPOSE
//  Machine-mode trap sequencer. Sits directly upstream of msrv32_csr_file.
//  Each cycle it:
//   - arbitrates decoded exceptions, pending/enabled interrupts and MRET;
//   - drives the CSR file's trap strobes (set_epc, set_cause, i_or_e, cause,
//     mie_clear, mie_set, instret_inc, misaligned_exception);
//   - drives PC-source select and pipeline flush to the fetch/PC mux.
// PARAMETERS
//  none (RV32 machine mode only; cause field fixed at 4 bits)
// PORTS
//  clock                  in   1  system clock, all state on rising edge
//  rst_in                 in   1  synchronous reset, active-low
//  illegal_instr_in       in   1  decoder: illegal opcode/funct
//  misaligned_instr_in    in   1  branch/jump target not word aligned
//  misaligned_load_in     in   1  load address misaligned
//  misaligned_store_in    in   1  store address misaligned
//  ecall_in               in   1  decoded ECALL
//  ebreak_in              in   1  decoded EBREAK
//  mret_in                in   1  decoded MRET
//  mie_in                 in   1  mstatus.MIE from CSR file
//  meie_in,mtie_in,msie_in in  1  mie register enables from CSR file
//  meip_in,mtip_in,msip_in in  1  mip pending bits from CSR file
//  i_or_e_out             out  1  1=interrupt, 0=exception (to mcause MSB)
//  cause_out              out  4  mcause code
//  set_cause_out          out  1  load mcause/mtval this cycle
//  set_epc_out            out  1  load mepc from pc this cycle
//  mie_clear_out          out  1  MPIE<=MIE, MIE<=0
//  mie_set_out            out  1  MIE<=MPIE (MRET)
//  instret_inc_out        out  1  one instruction retired
//  misaligned_exception_out out 1 trap is a misaligned fault (mtval<=iadder)
//  pc_src_out             out  2  00 BOOT, 01 EPC, 10 NEXT, 11 TRAP
//  flush_out              out  1  kill instruction in fetch/decode
// BEHAVIOUR
//  FSM states: RESET, OPERATE, TRAP_TAKEN, TRAP_RETURN. Moore outputs.
//  Transitions:
//   - RESET -> OPERATE unconditionally.
//   - OPERATE: exc -> TRAP_TAKEN; else irq -> TRAP_TAKEN;
//     else mret_in -> TRAP_RETURN; else stay in OPERATE.
//   - TRAP_TAKEN -> OPERATE; TRAP_RETURN -> OPERATE (one cycle each).
//  Definitions:
//   - exc = illegal|misaligned_instr|misaligned_load|misaligned_store|ecall|ebreak
//   - irq = mie_in & ((meie&meip)|(msie&msip)|(mtie&mtip))
//  Exception cause priority, high to low:
//   misaligned_instr 0, illegal 2, ebreak 3, ecall 11, misaligned_load 4,
//   misaligned_store 6.
//  Interrupt cause priority, high to low: MEI 11, MSI 3, MTI 7.
//  Simultaneous events: exception > interrupt > MRET. Losers are dropped,
//   not queued; an interrupt is re-evaluated every OPERATE cycle.
//  cause_out, i_or_e_out, misaligned_exception_out are registered on the
//   OPERATE->TRAP_TAKEN edge and held until the next trap entry.
//  Outputs per state (all others 0):
//   - RESET: pc_src=00, flush=1.
//   - OPERATE: pc_src=10; instret_inc=1 iff !exc & !irq (MRET retires).
//   - TRAP_TAKEN: pc_src=11, flush=1, set_epc=1, set_cause=1, mie_clear=1.
//   - TRAP_RETURN: pc_src=01, flush=1, mie_set=1.
//  Latency: trap detected in OPERATE cycle N; strobes and TRAP pc asserted in
//   cycle N+1; handler fetch from trap_address in N+2.
//  No back-to-back trap: an event present while in TRAP_TAKEN/TRAP_RETURN is
//   ignored (instruction is flushed).
//  Reset: rst_in=0 at any edge, from any state -> RESET next cycle.
//   Reset values: cause=0, i_or_e=0, misaligned=0, all strobes 0,
//   pc_src=00, flush=1. Reset mid-trap abandons the trap; no strobe is
//   issued after the reset edge.
// TESTING
//  1. Hold rst_in=0 3 cycles, release -> pc_src 00 then 10 on the next cycle;
//     flush 1->0; all strobes 0.
//  2. illegal_instr_in=1 in OPERATE -> next cycle set_cause=set_epc=mie_clear=1,
//     cause=2, i_or_e=0, pc_src=11; following cycle pc_src=10.
//  3. mie_in=1, mtie=mtip=1 and msie=msip=1 together -> cause=3, i_or_e=1;
//     repeat with mie_in=0 -> no trap, instret_inc=1.
//  4. misaligned_load_in=1 with meie=meip=mie=1 -> exception wins: cause=4,
//     i_or_e=0, misaligned_exception_out=1.
//  5. mret_in=1 -> next cycle mie_set=1, pc_src=01, flush=1, no set_epc;
//     mret_in + irq in the same cycle -> TRAP_TAKEN, cause=11 or 3/7 per priority.
//  6. rst_in=0 during TRAP_TAKEN -> next cycle RESET outputs; cause_out=0.

Source files
------------

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer for the msrv32 core: arbitrates exceptions,
// interrupts and MRET, and drives the CSR trap strobes plus PC select/flush.
module msrv32_trap_controller (
    input  logic       clock,
    input  logic       rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out
);

    typedef enum logic [1:0] {
        ST_RESET       = 2'd0,
        ST_OPERATE     = 2'd1,
        ST_TRAP_TAKEN  = 2'd2,
        ST_TRAP_RETURN = 2'd3
    } state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_NEXT = 2'b10;
    localparam logic [1:0] PC_TRAP = 2'b11;

    localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK           = 4'd3;
    localparam logic [3:0] CAUSE_ECALL            = 4'd11;
    localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] CAUSE_MEI              = 4'd11;
    localparam logic [3:0] CAUSE_MSI              = 4'd3;
    localparam logic [3:0] CAUSE_MTI              = 4'd7;

    state_t     state_q;
    logic [1:0] pc_src_q;
    logic       flush_q;
    logic       set_epc_q;
    logic       set_cause_q;
    logic       mie_clear_q;
    logic       mie_set_q;
    logic [3:0] cause_q;
    logic       i_or_e_q;
    logic       misaligned_q;

    logic       exc;
    logic       irq;
    logic       mei_hit;
    logic       msi_hit;
    logic       mti_hit;
    logic [3:0] exc_cause;
    logic [3:0] irq_cause;
    logic       exc_misaligned;
    logic [3:0] trap_cause_d;

    assign exc = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                 misaligned_store_in | ecall_in | ebreak_in;

    assign mei_hit = meie_in & meip_in;
    assign msi_hit = msie_in & msip_in;
    assign mti_hit = mtie_in & mtip_in;
    assign irq     = mie_in & (mei_hit | msi_hit | mti_hit);

    // NOTE: every signal gets a default before the priority chain so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        exc_cause      = CAUSE_MISALIGNED_STORE;
        exc_misaligned = 1'b0;
        if (misaligned_instr_in) begin
            exc_cause      = CAUSE_MISALIGNED_INSTR;
            exc_misaligned = 1'b1;
        end else if (illegal_instr_in) begin
            exc_cause = CAUSE_ILLEGAL;
        end else if (ebreak_in) begin
            exc_cause = CAUSE_EBREAK;
        end else if (ecall_in) begin
            exc_cause = CAUSE_ECALL;
        end else if (misaligned_load_in) begin
            exc_cause      = CAUSE_MISALIGNED_LOAD;
            exc_misaligned = 1'b1;
        end else if (misaligned_store_in) begin
            exc_cause      = CAUSE_MISALIGNED_STORE;
            exc_misaligned = 1'b1;
        end
    end

    always_comb begin
        irq_cause = CAUSE_MTI;
        if (mei_hit) begin
            irq_cause = CAUSE_MEI;
        end else if (msi_hit) begin
            irq_cause = CAUSE_MSI;
        end
    end

    // Exceptions always beat interrupts; the loser is simply dropped.
    assign trap_cause_d = exc ? exc_cause : irq_cause;

    // NOTE: state and registered outputs use non-blocking assignments so all
    // of them update together on the edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (!rst_in) begin
            state_q      <= ST_RESET;
            pc_src_q     <= PC_BOOT;
            flush_q      <= 1'b1;
            set_epc_q    <= 1'b0;
            set_cause_q  <= 1'b0;
            mie_clear_q  <= 1'b0;
            mie_set_q    <= 1'b0;
            cause_q      <= 4'd0;
            i_or_e_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            set_epc_q   <= 1'b0;
            set_cause_q <= 1'b0;
            mie_clear_q <= 1'b0;
            mie_set_q   <= 1'b0;
            case (state_q)
                ST_OPERATE: begin
                    if (exc || irq) begin
                        state_q      <= ST_TRAP_TAKEN;
                        pc_src_q     <= PC_TRAP;
                        flush_q      <= 1'b1;
                        set_epc_q    <= 1'b1;
                        set_cause_q  <= 1'b1;
                        mie_clear_q  <= 1'b1;
                        cause_q      <= trap_cause_d;
                        i_or_e_q     <= ~exc;
                        misaligned_q <= exc & exc_misaligned;
                    end else if (mret_in) begin
                        state_q   <= ST_TRAP_RETURN;
                        pc_src_q  <= PC_EPC;
                        flush_q   <= 1'b1;
                        mie_set_q <= 1'b1;
                    end else begin
                        state_q  <= ST_OPERATE;
                        pc_src_q <= PC_NEXT;
                        flush_q  <= 1'b0;
                    end
                end
                // Events seen in RESET or in a one-cycle trap state belong to a
                // flushed instruction, so they are ignored.
                ST_RESET, ST_TRAP_TAKEN, ST_TRAP_RETURN: begin
                    state_q  <= ST_OPERATE;
                    pc_src_q <= PC_NEXT;
                    flush_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_RESET;
                    pc_src_q <= PC_BOOT;
                    flush_q  <= 1'b1;
                end
            endcase
        end
    end

    // Retirement is the only output that depends on this cycle's inputs.
    assign instret_inc_out = (state_q == ST_OPERATE) & ~exc & ~irq;

    assign pc_src_out               = pc_src_q;
    assign flush_out                = flush_q;
    assign set_epc_out              = set_epc_q;
    assign set_cause_out            = set_cause_q;
    assign mie_clear_out            = mie_clear_q;
    assign mie_set_out              = mie_set_q;
    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign misaligned_exception_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Self-checking bench for msrv32_trap_controller: directed scenarios plus a
// randomized run compared against a priority-list reference model.
module tb_msrv32_trap_controller;

    logic       clock;
    logic       rst_in;
    logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in;
    logic       misaligned_store_in, ecall_in, ebreak_in, mret_in;
    logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
    logic       i_or_e_out, set_cause_out, set_epc_out, mie_clear_out;
    logic       mie_set_out, instret_inc_out, misaligned_exception_out, flush_out;
    logic [3:0] cause_out;
    logic [1:0] pc_src_out;

    int checks = 0;
    int errors = 0;

    msrv32_trap_controller dut (
        .clock                    (clock),
        .rst_in                   (rst_in),
        .illegal_instr_in         (illegal_instr_in),
        .misaligned_instr_in      (misaligned_instr_in),
        .misaligned_load_in       (misaligned_load_in),
        .misaligned_store_in      (misaligned_store_in),
        .ecall_in                 (ecall_in),
        .ebreak_in                (ebreak_in),
        .mret_in                  (mret_in),
        .mie_in                   (mie_in),
        .meie_in                  (meie_in),
        .mtie_in                  (mtie_in),
        .msie_in                  (msie_in),
        .meip_in                  (meip_in),
        .mtip_in                  (mtip_in),
        .msip_in                  (msip_in),
        .i_or_e_out               (i_or_e_out),
        .cause_out                (cause_out),
        .set_cause_out            (set_cause_out),
        .set_epc_out              (set_epc_out),
        .mie_clear_out            (mie_clear_out),
        .mie_set_out              (mie_set_out),
        .instret_inc_out          (instret_inc_out),
        .misaligned_exception_out (misaligned_exception_out),
        .pc_src_out               (pc_src_out),
        .flush_out                (flush_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: what the previous edge did to the machine.
    localparam int L_RESET = 0;
    localparam int L_RUN   = 1;
    localparam int L_TRAP  = 2;
    localparam int L_MRET  = 3;

    int         m_last  = L_RESET;
    logic [3:0] m_cause = 4'd0;
    logic       m_ioe   = 1'b0;
    logic       m_mis   = 1'b0;

    // Walk the architectural priority lists; the first hit wins.
    function automatic void scan(output bit take, output bit is_irq,
                                 output logic [3:0] code, output bit mis);
        int  exc_code [6] = '{0, 2, 3, 11, 4, 6};
        bit  exc_is_mis [6] = '{1, 0, 0, 0, 1, 1};
        bit  exc_hit [6];
        int  irq_code [3] = '{11, 3, 7};
        bit  irq_hit [3];
        exc_hit = '{misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
                    misaligned_load_in, misaligned_store_in};
        irq_hit = '{mie_in & meie_in & meip_in, mie_in & msie_in & msip_in,
                    mie_in & mtie_in & mtip_in};
        take = 0; is_irq = 0; code = 4'd0; mis = 0;
        for (int i = 0; i < 6; i++) begin
            if (exc_hit[i] && !take) begin
                take = 1; code = exc_code[i][3:0]; mis = exc_is_mis[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (irq_hit[i] && !take) begin
                take = 1; is_irq = 1; code = irq_code[i][3:0];
            end
        end
    endfunction

    function automatic logic [13:0] expected_vec();
        bit take, is_irq, mis;
        logic [3:0] code;
        logic [1:0] pc;
        scan(take, is_irq, code, mis);
        pc = (m_last == L_RESET) ? 2'b00 : (m_last == L_RUN) ? 2'b10 :
             (m_last == L_TRAP)  ? 2'b11 : 2'b01;
        return {pc, m_last != L_RUN, m_last == L_TRAP, m_last == L_TRAP,
                m_last == L_TRAP, m_last == L_MRET, (m_last == L_RUN) && !take,
                m_cause, m_ioe, m_mis};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {pc_src_out, flush_out, set_epc_out, set_cause_out, mie_clear_out,
                mie_set_out, instret_inc_out, cause_out, i_or_e_out,
                misaligned_exception_out};
    endfunction

    // Advance the model with the inputs held this cycle, then clock the DUT.
    task automatic cycle();
        bit take, is_irq, mis;
        logic [3:0] code;
        if (!rst_in) begin
            m_last = L_RESET; m_cause = 4'd0; m_ioe = 0; m_mis = 0;
        end else if (m_last == L_RUN) begin
            scan(take, is_irq, code, mis);
            if (take) begin
                m_last = L_TRAP; m_cause = code; m_ioe = is_irq; m_mis = mis;
            end else if (mret_in) begin
                m_last = L_MRET;
            end
        end else begin
            m_last = L_RUN;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        illegal_instr_in = 0; misaligned_instr_in = 0; misaligned_load_in = 0;
        misaligned_store_in = 0; ecall_in = 0; ebreak_in = 0; mret_in = 0;
        mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0;
        meip_in = 0; mtip_in = 0; msip_in = 0;
    endtask

    task automatic test_reset();
        rst_in = 0;
        clear_inputs();
        repeat (3) cycle();
        checks++;
        if ({pc_src_out, flush_out} !== 3'b001) begin
            errors++; $display("FAIL reset_pc_flush got %b exp 001", {pc_src_out, flush_out});
        end
        checks++;
        if ({set_epc_out, set_cause_out, mie_clear_out, mie_set_out, cause_out,
             i_or_e_out, misaligned_exception_out} !== 10'd0) begin
            errors++; $display("FAIL reset_strobes_cause got %b exp 0", {set_epc_out,
                set_cause_out, mie_clear_out, mie_set_out, cause_out, i_or_e_out,
                misaligned_exception_out});
        end
        rst_in = 1;
        #1;
        checks++;
        if (pc_src_out !== 2'b00) begin
            errors++; $display("FAIL release_still_boot got %b exp 00", pc_src_out);
        end
        cycle();
        checks++;
        if ({pc_src_out, flush_out} !== 3'b100) begin
            errors++; $display("FAIL after_release got %b exp 100", {pc_src_out, flush_out});
        end
    endtask

    task automatic test_illegal();
        illegal_instr_in = 1;
        #1;
        checks++;
        if (instret_inc_out !== 1'b0) begin
            errors++; $display("FAIL illegal_no_retire got %b exp 0", instret_inc_out);
        end
        cycle();
        clear_inputs();
        checks++;
        if ({set_cause_out, set_epc_out, mie_clear_out, mie_set_out, pc_src_out, flush_out}
            !== 7'b1110_111) begin
            errors++; $display("FAIL illegal_strobes got %b exp 1110111", {set_cause_out,
                set_epc_out, mie_clear_out, mie_set_out, pc_src_out, flush_out});
        end
        checks++;
        if ({cause_out, i_or_e_out} !== 5'b0010_0) begin
            errors++; $display("FAIL illegal_cause got %h/%b exp 2/0", cause_out, i_or_e_out);
        end
        cycle();
        checks++;
        if ({pc_src_out, set_epc_out, cause_out} !== 7'b10_0_0010) begin
            errors++; $display("FAIL illegal_return_hold got %b exp 1000010",
                {pc_src_out, set_epc_out, cause_out});
        end
    endtask

    task automatic test_irq_priority();
        mie_in = 1; mtie_in = 1; mtip_in = 1; msie_in = 1; msip_in = 1;
        cycle();
        clear_inputs();
        checks++;
        if ({cause_out, i_or_e_out, pc_src_out} !== 7'b0011_1_11) begin
            errors++; $display("FAIL irq_msi_over_mti got %h/%b/%b exp 3/1/11",
                cause_out, i_or_e_out, pc_src_out);
        end
        cycle();
        mie_in = 0; mtie_in = 1; mtip_in = 1; msie_in = 1; msip_in = 1; meie_in = 1; meip_in = 1;
        #1;
        checks++;
        if (instret_inc_out !== 1'b1) begin
            errors++; $display("FAIL masked_irq_retires got %b exp 1", instret_inc_out);
        end
        cycle();
        clear_inputs();
        checks++;
        if ({pc_src_out, set_epc_out} !== 3'b10_0) begin
            errors++; $display("FAIL masked_irq_no_trap got %b exp 100", {pc_src_out, set_epc_out});
        end
    endtask

    task automatic test_exc_over_irq();
        misaligned_load_in = 1; meie_in = 1; meip_in = 1; mie_in = 1;
        cycle();
        clear_inputs();
        checks++;
        if ({cause_out, i_or_e_out, misaligned_exception_out} !== 6'b0100_0_1) begin
            errors++; $display("FAIL exc_beats_irq got %h/%b/%b exp 4/0/1",
                cause_out, i_or_e_out, misaligned_exception_out);
        end
        cycle();
    endtask

    task automatic test_mret();
        mret_in = 1;
        #1;
        checks++;
        if (instret_inc_out !== 1'b1) begin
            errors++; $display("FAIL mret_retires got %b exp 1", instret_inc_out);
        end
        cycle();
        clear_inputs();
        checks++;
        if ({mie_set_out, pc_src_out, flush_out, set_epc_out, mie_clear_out} !== 6'b1_01_1_0_0) begin
            errors++; $display("FAIL mret_return got %b exp 101100", {mie_set_out,
                pc_src_out, flush_out, set_epc_out, mie_clear_out});
        end
        cycle();
        mret_in = 1; mie_in = 1; meie_in = 1; meip_in = 1; mtie_in = 1; mtip_in = 1;
        cycle();
        clear_inputs();
        checks++;
        if ({cause_out, i_or_e_out, set_epc_out, mie_set_out, pc_src_out} !== 9'b1011_1_1_0_11) begin
            errors++; $display("FAIL irq_beats_mret got %h/%b/%b/%b/%b exp b/1/1/0/11",
                cause_out, i_or_e_out, set_epc_out, mie_set_out, pc_src_out);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        ecall_in = 1;
        cycle();
        checks++;
        if ({cause_out, pc_src_out} !== 6'b1011_11) begin
            errors++; $display("FAIL b2b_first got %h/%b exp b/11", cause_out, pc_src_out);
        end
        ebreak_in = 1;
        cycle();
        clear_inputs();
        checks++;
        if ({pc_src_out, set_epc_out, cause_out} !== 7'b10_0_1011) begin
            errors++; $display("FAIL b2b_ignored got %b exp 1001011",
                {pc_src_out, set_epc_out, cause_out});
        end
    endtask

    task automatic test_reset_mid_trap();
        misaligned_store_in = 1;
        cycle();
        clear_inputs();
        rst_in = 0;
        cycle();
        checks++;
        if ({pc_src_out, flush_out, set_epc_out, set_cause_out, mie_clear_out, cause_out,
             misaligned_exception_out} !== 11'b00_1_0_0_0_0000_0) begin
            errors++; $display("FAIL reset_mid_trap got %b exp 00100000000", {pc_src_out,
                flush_out, set_epc_out, set_cause_out, mie_clear_out, cause_out,
                misaligned_exception_out});
        end
        rst_in = 1;
        cycle();
    endtask

    task automatic test_random();
        logic [13:0] exp_v;
        logic [13:0] got_v;
        for (int n = 0; n < 400; n++) begin
            rst_in              = ($urandom_range(0, 39) != 0);
            illegal_instr_in    = ($urandom_range(0, 9) == 0);
            misaligned_instr_in = ($urandom_range(0, 11) == 0);
            misaligned_load_in  = ($urandom_range(0, 11) == 0);
            misaligned_store_in = ($urandom_range(0, 11) == 0);
            ecall_in            = ($urandom_range(0, 11) == 0);
            ebreak_in           = ($urandom_range(0, 11) == 0);
            mret_in             = ($urandom_range(0, 3) == 0);
            mie_in  = $urandom_range(0, 1); meie_in = $urandom_range(0, 1);
            mtie_in = $urandom_range(0, 1); msie_in = $urandom_range(0, 1);
            meip_in = ($urandom_range(0, 3) == 0); mtip_in = ($urandom_range(0, 3) == 0);
            msip_in = ($urandom_range(0, 3) == 0);
            #1;
            exp_v = expected_vec();
            got_v = dut_vec();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d got %b exp %b (pc,fl,epc,cs,mc,ms,ir,cause,ie,mis)",
                    n, got_v, exp_v);
            end
            cycle();
        end
        clear_inputs();
        rst_in = 1;
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_irq_priority();
        test_exc_over_irq();
        test_mret();
        test_back_to_back();
        test_reset_mid_trap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
